keypad_scan: RTL and testbench
==============================

# keypad_scan

4×4 matrix keypad scanner: drives rows active-low one at a time, samples the four columns, debounces, and delivers one 4-bit key code per press through a ready/ack handshake. It is the input-side counterpart to the multiplexed 7-segment display path and feeds hex data to the CPU input port, or to the monitor logic, on the board clock. It locks onto one key per press, waits for release, and flags overrun when a key arrives before the previous code is acknowledged.

## Interface
- SCAN_DIV, 24'd11999: prescaler terminal count. One row slot lasts SCAN_DIV+1 clocks (1 ms at 12 MHz). Must be ≥ 3.
- DEB_CNT, 4'd8: consecutive agreeing ticks required to accept a press, and also to accept a release. Must be ≥ 1.

- clk  in  1  board clock; the only clock.
- nRst  in  1  asynchronous, active-low reset.
- row  out  4  row drive, active-low; exactly one bit is low at any time.
- col  in  4  column sense, active-low, asynchronous; passed through an internal 2-FF synchronizer.
- keyAck  in  1  consumer acknowledge; sampled on the clock edge.
- keyCode  out  4  key code {rowIdx[1:0], colIdx[1:0]}.
- keyReady  out  1  keyCode is valid and not yet acknowledged.
- keyOverrun  out  1  a key was dropped because keyReady was still high.
- keyDown  out  1  a debounced key is currently held.

## Operation
- **Prescaler:** counts 0..SCAN_DIV and wraps to 0. A tick is the clock where the count equals SCAN_DIV. All FSM decisions occur only on ticks, using the synchronized col value (colS).
- **rowIdx:** row = ~(4'b0001 << rowIdx).
- **colIdx:** the lowest-numbered low bit of colS. This sets column priority when several keys are pressed in one row.
- **State SCAN** (on tick):
  - colS == 4'hF → rowIdx+1, wrapping 3→0.
  - Otherwise → capture cand = {rowIdx, colIdx} and set debCnt = 1. The row is frozen.
  - If DEB_CNT == 1 → go directly to PRESSED and deliver. Otherwise → CONFIRM.
- **State CONFIRM** (row frozen; on tick):
  - colS[cand col] low → debCnt+1. Reaching DEB_CNT → PRESSED and deliver.
  - colS[cand col] high → SCAN and rowIdx+1. No delivery.
- **State PRESSED** (row frozen; on tick):
  - colS[cand col] high → relCnt+1. colS[cand col] low → relCnt = 0.
  - relCnt reaching DEB_CNT → SCAN and rowIdx+1.
  - Other keys are ignored throughout.
- **keyDown** = (state == PRESSED).
- **Delivery:**
  - keyReady = 0 → keyCode ← cand, keyReady ← 1.
  - keyReady = 1 → keyCode unchanged, keyOverrun ← 1, new key dropped.
- **Ack:** keyAck with keyReady = 1 → keyReady ← 0 and keyOverrun ← 0. keyAck with keyReady = 0 has no effect.
- **Delivery and ack on the same clock:** the old code is consumed, cand is loaded, keyReady stays 1, keyOverrun is not set.
- **Reset** (asynchronous, any state):
  - row = 4'b1110, rowIdx = 0, state = SCAN, prescaler = 0, debCnt = relCnt = 0.
  - keyCode = 4'h0, keyReady = 0, keyOverrun = 0, keyDown = 0.
  - The synchronizer resets to 4'hF.

## Timing
- row, keyCode, keyReady, keyOverrun and keyDown are all registered.
- Row changes on the tick clock edge, so each row is driven for SCAN_DIV+1 clocks before its sample.
- colS lags col by 2 clocks. SCAN_DIV ≥ 3 guarantees colS reflects the current row at the tick.
- **Press latency:** keyReady rises on the tick edge that completes confirmation. That is (DEB_CNT−1) ticks after the capture tick, and the capture occurs within 4 slots of a stable press.
- **Release latency:** DEB_CNT ticks of released colS, then scanning resumes at the next row.
- **Ack latency:** keyReady falls on the edge that samples keyAck = 1.
- **keyAck held high:** clears each newly delivered key in the same cycle it is loaded. Consumers pulse keyAck.

## Test plan
Bench parameters: SCAN_DIV = 3, DEB_CNT = 2.

- **Reset and scan:** hold nRst low mid-count, col = 4'hF → row = 1110 and all other outputs 0. After release, row steps 1110→1101→1011→0111→1110, 4 clocks per step.
- **Single press:** the keypad model pulls col[1] low while row[2] is low; hold it → keyCode = 4'h9, keyReady = 1, keyDown = 1, row frozen at 1011. Pulse keyAck → keyReady = 0 next clock. Release for 2 ticks → keyDown = 0 and row steps to 0111.
- **Bounce:** col low for exactly one tick → keyReady stays 0 and scan resumes at the next row.
- **Overrun:** press/release key 5, then key A, with no ack → keyCode = 4'h5, keyOverrun = 1. Then keyAck → keyReady = 0, keyOverrun = 0.
- **Multi-key:** row 1 col 0 and col 3 pressed together → keyCode = 4'h4. While it is held, press key F → no second delivery.
- **Reset mid-operation:** assert nRst in PRESSED with keyReady = 1 → all outputs return to reset values immediately. After release, scanning restarts at row 0.

Source files
------------

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: active-low row drive, synchronized column sense,
// tick-based press/release debounce and a one-deep ready/ack key code register.
module keypad_scan #(
    parameter logic [23:0] SCAN_DIV = 24'd11999,
    parameter logic [3:0]  DEB_CNT  = 4'd8
) (
    input  logic       clk,
    input  logic       nRst,
    output logic [3:0] row,
    input  logic [3:0] col,
    input  logic       keyAck,
    output logic [3:0] keyCode,
    output logic       keyReady,
    output logic       keyOverrun,
    output logic       keyDown
);

    typedef enum logic [1:0] {
        SCAN    = 2'd0,
        CONFIRM = 2'd1,
        PRESSED = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  col_meta;
    logic [3:0]  col_s;
    logic [23:0] presc;
    logic        tick;
    logic [1:0]  row_idx;
    logic [1:0]  row_next;
    logic [1:0]  col_idx;
    logic        any_low;
    logic [3:0]  cand;
    logic        cand_low;
    logic [3:0]  deb_cnt;
    logic [3:0]  deb_next;
    logic [3:0]  rel_cnt;
    logic [3:0]  rel_next;
    logic        deliver;
    logic [3:0]  deliver_code;
    logic        ack;

    // NOTE: the synchronizer resets to all-released so reset never looks like a press.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            col_meta <= 4'hF;
            col_s    <= 4'hF;
        end else begin
            col_meta <= col;
            col_s    <= col_meta;
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            presc <= 24'd0;
        end else if (presc == SCAN_DIV) begin
            presc <= 24'd0;
        end else begin
            presc <= presc + 24'd1;
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        tick         = (presc == SCAN_DIV);
        any_low      = (col_s != 4'hF);
        row_next     = row_idx + 2'd1;
        deb_next     = deb_cnt + 4'd1;
        rel_next     = rel_cnt + 4'd1;
        cand_low     = ~col_s[cand[1:0]];
        ack          = keyAck & keyReady;
        deliver      = 1'b0;
        deliver_code = cand;

        // Lowest-numbered pressed column wins within a row.
        casez (col_s)
            4'b???0: col_idx = 2'd0;
            4'b??01: col_idx = 2'd1;
            4'b?011: col_idx = 2'd2;
            default: col_idx = 2'd3;
        endcase

        if (tick) begin
            if (state == SCAN && any_low && DEB_CNT == 4'd1) begin
                deliver      = 1'b1;
                deliver_code = {row_idx, col_idx};
            end else if (state == CONFIRM && cand_low && deb_next == DEB_CNT) begin
                deliver      = 1'b1;
            end
        end
    end

    // Scan / debounce FSM; the row drive is frozen outside SCAN.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state   <= SCAN;
            row_idx <= 2'd0;
            row     <= 4'b1110;
            cand    <= 4'h0;
            deb_cnt <= 4'd0;
            rel_cnt <= 4'd0;
            keyDown <= 1'b0;
        end else if (tick) begin
            unique case (state)
                SCAN: begin
                    if (!any_low) begin
                        row_idx <= row_next;
                        row     <= ~(4'b0001 << row_next);
                    end else begin
                        cand    <= {row_idx, col_idx};
                        deb_cnt <= 4'd1;
                        if (DEB_CNT == 4'd1) begin
                            state   <= PRESSED;
                            rel_cnt <= 4'd0;
                            keyDown <= 1'b1;
                        end else begin
                            state <= CONFIRM;
                        end
                    end
                end
                CONFIRM: begin
                    if (cand_low) begin
                        deb_cnt <= deb_next;
                        if (deb_next == DEB_CNT) begin
                            state   <= PRESSED;
                            rel_cnt <= 4'd0;
                            keyDown <= 1'b1;
                        end
                    end else begin
                        state   <= SCAN;
                        row_idx <= row_next;
                        row     <= ~(4'b0001 << row_next);
                    end
                end
                PRESSED: begin
                    if (cand_low) begin
                        rel_cnt <= 4'd0;
                    end else if (rel_next == DEB_CNT) begin
                        state   <= SCAN;
                        rel_cnt <= 4'd0;
                        keyDown <= 1'b0;
                        row_idx <= row_next;
                        row     <= ~(4'b0001 << row_next);
                    end else begin
                        rel_cnt <= rel_next;
                    end
                end
                default: begin
                    state <= SCAN;
                end
            endcase
        end
    end

    // An ack on the delivery edge frees the slot, so the new code is taken without overrun.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            keyCode    <= 4'h0;
            keyReady   <= 1'b0;
            keyOverrun <= 1'b0;
        end else if (deliver) begin
            if (!keyReady || keyAck) begin
                keyCode    <= deliver_code;
                keyReady   <= 1'b1;
                keyOverrun <= 1'b0;
            end else begin
                keyOverrun <= 1'b1;
            end
        end else if (ack) begin
            keyReady   <= 1'b0;
            keyOverrun <= 1'b0;
        end
    end

    a_row_one_low: assert property (@(posedge clk) disable iff (!nRst) $onehot(~row));
    a_overrun_ready: assert property (@(posedge clk) disable iff (!nRst) keyOverrun |-> keyReady);

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with a behavioural 4x4 keypad (SCAN_DIV=3, DEB_CNT=2).
module tb_keypad_scan;

    logic        clk;
    logic        nRst;
    logic [3:0]  row;
    logic [3:0]  col;
    logic        keyAck;
    logic [3:0]  keyCode;
    logic        keyReady;
    logic        keyOverrun;
    logic        keyDown;
    logic [15:0] keys;
    int          checks;
    int          errors;

    keypad_scan #(
        .SCAN_DIV(24'd3),
        .DEB_CNT (4'd2)
    ) dut (
        .clk       (clk),
        .nRst      (nRst),
        .row       (row),
        .col       (col),
        .keyAck    (keyAck),
        .keyCode   (keyCode),
        .keyReady  (keyReady),
        .keyOverrun(keyOverrun),
        .keyDown   (keyDown)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Key (r,c) pulls column c low while row r is driven low.
    always_comb begin
        col = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !row[r]) col[c] = 1'b0;
            end
        end
    end

    function automatic logic [3:0] probe(input int sel);
        case (sel)
            0:       return {3'b000, keyReady};
            1:       return {3'b000, keyDown};
            default: return row;
        endcase
    endfunction

    // sel: 0 = keyReady, 1 = keyDown, 2 = row. Polls on falling edges with a cycle budget.
    task automatic wait_for(input int sel, input logic [3:0] val, input int budget, input string name);
        int n;
        logic [3:0] cur;
        n = 0;
        cur = probe(sel);
        while (cur !== val && n < budget) begin
            @(negedge clk);
            n++;
            cur = probe(sel);
        end
        checks++;
        if (cur !== val) begin
            errors++;
            $display("FAIL %s: got %h, expected %h within %0d cycles", name, cur, val, budget);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if ({row, keyCode, keyReady, keyOverrun, keyDown} !== {4'b1110, 4'h0, 3'b000}) begin
            errors++;
            $display("FAIL %s: row=%b code=%h rdy=%b ovr=%b down=%b, expected 1110/0/0/0/0",
                     name, row, keyCode, keyReady, keyOverrun, keyDown);
        end
    endtask

    task automatic pulse_ack();
        keyAck = 1'b1;
        @(negedge clk);
        keyAck = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] exp_rows [0:4];
        exp_rows = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
        nRst = 1'b0;
        repeat (3) @(negedge clk);
        nRst = 1'b1;
        repeat (6) @(negedge clk);
        #2 nRst = 1'b0;
        #1 check_reset_outputs("reset_async");
        @(negedge clk);
        @(negedge clk);
        nRst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (row !== 4'b1110) begin
            errors++;
            $display("FAIL scan_hold0: row=%b, expected 1110", row);
        end
        for (int i = 1; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (row !== exp_rows[i]) begin
                errors++;
                $display("FAIL scan_step%0d: row=%b, expected %b", i, row, exp_rows[i]);
            end
            repeat (3) @(negedge clk);
            checks++;
            if (row !== exp_rows[i]) begin
                errors++;
                $display("FAIL scan_hold%0d: row=%b, expected %b", i, row, exp_rows[i]);
            end
        end
        checks++;
        if (keyReady !== 1'b0 || keyDown !== 1'b0) begin
            errors++;
            $display("FAIL scan_idle: rdy=%b down=%b, expected 0/0", keyReady, keyDown);
        end
    endtask

    task automatic test_single_press();
        keys[9] = 1'b1;
        wait_for(0, 4'h1, 80, "press9_ready");
        checks++;
        if (keyCode !== 4'h9 || keyDown !== 1'b1 || row !== 4'b1011) begin
            errors++;
            $display("FAIL press9_state: code=%h down=%b row=%b, expected 9/1/1011", keyCode, keyDown, row);
        end
        repeat (12) @(negedge clk);
        checks++;
        if (row !== 4'b1011 || keyReady !== 1'b1) begin
            errors++;
            $display("FAIL press9_frozen: row=%b rdy=%b, expected 1011/1", row, keyReady);
        end
        pulse_ack();
        checks++;
        if (keyReady !== 1'b0 || keyDown !== 1'b1) begin
            errors++;
            $display("FAIL press9_ack: rdy=%b down=%b, expected 0/1", keyReady, keyDown);
        end
        keys[9] = 1'b0;
        wait_for(1, 4'h0, 20, "release9_down");
        checks++;
        if (row !== 4'b0111 || keyReady !== 1'b0) begin
            errors++;
            $display("FAIL release9_row: row=%b rdy=%b, expected 0111/0", row, keyReady);
        end
    endtask

    task automatic test_bounce();
        wait_for(2, 4'b0111, 40, "bounce_sync_a");
        wait_for(2, 4'b1110, 40, "bounce_sync_b");
        keys[2] = 1'b1;
        repeat (4) @(negedge clk);
        keys[2] = 1'b0;
        checks++;
        if (row !== 4'b1110 || keyDown !== 1'b0) begin
            errors++;
            $display("FAIL bounce_capture: row=%b down=%b, expected 1110/0", row, keyDown);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (row !== 4'b1101 || keyReady !== 1'b0 || keyDown !== 1'b0) begin
            errors++;
            $display("FAIL bounce_reject: row=%b rdy=%b down=%b, expected 1101/0/0", row, keyReady, keyDown);
        end
    endtask

    task automatic test_overrun();
        keys[5] = 1'b1;
        wait_for(0, 4'h1, 80, "press5_ready");
        checks++;
        if (keyCode !== 4'h5 || keyOverrun !== 1'b0) begin
            errors++;
            $display("FAIL press5_code: code=%h ovr=%b, expected 5/0", keyCode, keyOverrun);
        end
        keys[5] = 1'b0;
        wait_for(1, 4'h0, 20, "release5_down");
        keys[10] = 1'b1;
        wait_for(1, 4'h1, 80, "pressA_down");
        checks++;
        if (keyCode !== 4'h5 || keyReady !== 1'b1 || keyOverrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set: code=%h rdy=%b ovr=%b, expected 5/1/1", keyCode, keyReady, keyOverrun);
        end
        keys[10] = 1'b0;
        wait_for(1, 4'h0, 20, "releaseA_down");
        pulse_ack();
        checks++;
        if (keyReady !== 1'b0 || keyOverrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_ack: rdy=%b ovr=%b, expected 0/0", keyReady, keyOverrun);
        end
    endtask

    task automatic test_multi_key();
        keys[4] = 1'b1;
        keys[7] = 1'b1;
        wait_for(0, 4'h1, 80, "multi_ready");
        checks++;
        if (keyCode !== 4'h4 || row !== 4'b1101) begin
            errors++;
            $display("FAIL multi_priority: code=%h row=%b, expected 4/1101", keyCode, row);
        end
        pulse_ack();
        keys[15] = 1'b1;
        repeat (40) @(negedge clk);
        checks++;
        if (keyReady !== 1'b0 || keyDown !== 1'b1 || row !== 4'b1101 || keyCode !== 4'h4) begin
            errors++;
            $display("FAIL multi_ignore: rdy=%b down=%b row=%b code=%h, expected 0/1/1101/4",
                     keyReady, keyDown, row, keyCode);
        end
        keys = 16'h0000;
        wait_for(1, 4'h0, 20, "multi_release");
    endtask

    task automatic test_ack_same_cycle();
        keys[5] = 1'b1;
        wait_for(0, 4'h1, 80, "same_pre_ready");
        keys[5] = 1'b0;
        wait_for(1, 4'h0, 20, "same_pre_release");
        wait_for(2, 4'b1110, 40, "same_sync_a");
        keys[11] = 1'b1;
        wait_for(2, 4'b1011, 40, "same_sync_b");
        repeat (7) @(negedge clk);
        checks++;
        if (keyReady !== 1'b1 || keyCode !== 4'h5) begin
            errors++;
            $display("FAIL same_before: rdy=%b code=%h, expected 1/5", keyReady, keyCode);
        end
        keyAck = 1'b1;
        @(negedge clk);
        keyAck = 1'b0;
        checks++;
        if (keyReady !== 1'b1 || keyCode !== 4'hB || keyOverrun !== 1'b0 || keyDown !== 1'b1) begin
            errors++;
            $display("FAIL same_cycle: rdy=%b code=%h ovr=%b down=%b, expected 1/B/0/1",
                     keyReady, keyCode, keyOverrun, keyDown);
        end
        pulse_ack();
        keys[11] = 1'b0;
        wait_for(1, 4'h0, 20, "same_release");
    endtask

    task automatic test_reset_mid();
        keys[9] = 1'b1;
        wait_for(0, 4'h1, 80, "mid_ready");
        checks++;
        if (keyDown !== 1'b1) begin
            errors++;
            $display("FAIL mid_pressed: down=%b, expected 1", keyDown);
        end
        #3 nRst = 1'b0;
        #1 check_reset_outputs("mid_reset");
        keys = 16'h0000;
        @(negedge clk);
        @(negedge clk);
        nRst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (row !== 4'b1110) begin
            errors++;
            $display("FAIL mid_restart0: row=%b, expected 1110", row);
        end
        @(negedge clk);
        checks++;
        if (row !== 4'b1101 || keyReady !== 1'b0) begin
            errors++;
            $display("FAIL mid_restart1: row=%b rdy=%b, expected 1101/0", row, keyReady);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        keys   = 16'h0000;
        keyAck = 1'b0;
        nRst   = 1'b0;
        test_reset();
        test_single_press();
        test_bounce();
        test_overrun();
        test_multi_key();
        test_ack_same_cycle();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
